// File: rtl/ccg_sweep_pkg.sv
// Shared types and helpers for the CCG truth-table sweeper and its MISR.
// The MISR step is written for up to 32 signature bits so one function serves every width.
package ccg_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        DONE
    } sweep_state_t;

    localparam logic [31:0] DEFAULT_POLY = 32'h0000_0009;

    function automatic logic [31:0] misr_step(
        input logic [31:0] sig,
        input logic [31:0] din,
        input logic [31:0] poly,
        input int          width
    );
        logic [31:0] mask;
        logic [31:0] shifted;
        mask    = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        shifted = (sig << 1) & mask;
        if (sig[width-1])
            shifted = shifted ^ poly;
        return (shifted ^ din) & mask;
    endfunction

endpackage

// File: rtl/ccg_misr.sv
// Galois MISR that compacts one N_OUT-bit sample per enabled cycle into a signature.
module ccg_misr
    import ccg_sweep_pkg::*;
#(
    parameter int              N_OUT = 10,
    parameter logic [N_OUT-1:0] POLY = N_OUT'(DEFAULT_POLY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [N_OUT-1:0] din,
    output logic [N_OUT-1:0] sig
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sig <= '0;
        else if (clear)
            sig <= '0;
        else if (enable)
            sig <= N_OUT'(misr_step(32'(sig), 32'(din), 32'(POLY), N_OUT));
    end

endmodule

// File: rtl/ccg_truth_table_sweeper.sv
// Clocked harness that walks a combinational DUT through its input vectors, waits for the
// outputs to settle, and folds each captured output word into a MISR signature.
module ccg_truth_table_sweeper
    import ccg_sweep_pkg::*;
#(
    parameter int               N_IN   = 3,
    parameter int               N_OUT  = 10,
    parameter int               SETTLE = 1,
    parameter logic [N_OUT-1:0] POLY   = N_OUT'(DEFAULT_POLY)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [N_IN-1:0]   vec_in,
    input  logic [N_OUT-1:0]  golden,
    output logic [N_IN-1:0]   x_out,
    input  logic [N_OUT-1:0]  f_in,
    output logic              busy,
    output logic              done,
    output logic [N_OUT-1:0]  signature,
    output logic [N_IN:0]     vec_cnt,
    output logic              pass
);

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE);

    sweep_state_t     state;
    sweep_state_t     state_next;
    logic             mode_q;
    logic [N_OUT-1:0] golden_q;
    logic [3:0]       wait_cnt;
    logic             accept;
    logic             capture;
    logic             last_vec;
    logic [N_OUT-1:0] sig_next;

    assign last_vec = mode_q || (x_out == '1);
    assign sig_next = N_OUT'(misr_step(32'(signature), 32'(f_in), 32'(POLY), N_OUT));

    // The SETTLE parameter shadows the enum literal, so state names are package-qualified.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ccg_sweep_pkg::IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
        done       = 1'b0;
        case (state)
            ccg_sweep_pkg::IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ccg_sweep_pkg::SETTLE;
                end
            end
            ccg_sweep_pkg::SETTLE: begin
                if (wait_cnt == 4'd0)
                    state_next = ccg_sweep_pkg::CAPTURE;
            end
            ccg_sweep_pkg::CAPTURE: begin
                capture    = 1'b1;
                state_next = last_vec ? ccg_sweep_pkg::DONE : ccg_sweep_pkg::SETTLE;
            end
            ccg_sweep_pkg::DONE: begin
                done       = 1'b1;
                state_next = ccg_sweep_pkg::IDLE;
            end
            default: state_next = ccg_sweep_pkg::IDLE;
        endcase
    end

    // pass is decided on the final capture edge so it appears together with done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= 1'b0;
            golden_q <= '0;
            wait_cnt <= 4'd0;
            x_out    <= '0;
            vec_cnt  <= '0;
            busy     <= 1'b0;
            pass     <= 1'b0;
        end else begin
            if (accept) begin
                mode_q   <= mode;
                golden_q <= golden;
                vec_cnt  <= '0;
                busy     <= 1'b1;
                x_out    <= mode ? vec_in : '0;
                wait_cnt <= SETTLE_INIT;
            end
            if (state == ccg_sweep_pkg::SETTLE && wait_cnt != 4'd0)
                wait_cnt <= wait_cnt - 4'd1;
            if (capture) begin
                vec_cnt <= vec_cnt + (N_IN+1)'(1);
                if (last_vec) begin
                    pass <= (sig_next == golden_q);
                end else begin
                    x_out    <= x_out + N_IN'(1);
                    wait_cnt <= SETTLE_INIT;
                end
            end
            if (state == ccg_sweep_pkg::DONE)
                busy <= 1'b0;
        end
    end

    ccg_misr #(
        .N_OUT (N_OUT),
        .POLY  (POLY)
    ) u_misr (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .enable (capture),
        .din    (f_in),
        .sig    (signature)
    );

endmodule
